// File: rtl/divide_prog_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package divide_prog_pkg;

    // Smallest legal divisor; a write below this is rejected as an error.
    localparam int DIV_MIN = 1;

    // Width of a channel index, never less than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Duty compare: the output is high once the count reaches half the divisor
    // (truncating), so every period begins with its low phase.
    function automatic logic duty_high(input logic [31:0] cnt, input logic [31:0] dv);
        return (cnt >= (dv >> 1));
    endfunction

endpackage

// File: rtl/divide_prog_if.sv
// Divisor configuration port: valid/ready write with a one-cycle error pulse.
interface divide_prog_if import divide_prog_pkg::*; #(
    parameter int CH    = 4,
    parameter int WIDTH = 16
) ();
    localparam int CHW = ch_width(CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_ch, output cfg_div,
                    input  cfg_ready, input  cfg_err);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div,
                    output cfg_ready, output cfg_err);
endinterface

// File: rtl/divide_prog_chan.sv
// One divider channel: dual-edge phase generation, shadow divisor and
// period-boundary apply so the output never produces a runt pulse.
module divide_prog_chan import divide_prog_pkg::*; #(
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_div_i,
    output logic             clkout_o,
    output logic             tick_o,
    output logic             pending_o
);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);

    logic [WIDTH-1:0] cnt_p_q, cnt_p_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q;
    logic             pending_q, pending_d;
    logic             last;
    logic             apply;

    // Next-state: wrap/restart the counter, swap in a pending divisor at a boundary.
    always_comb begin
        last  = (cnt_p_q == div_act_q - WIDTH'(1));
        // A disabled channel has no period in progress, so a pending divisor
        // may take effect right away; sync restarts the period and applies too.
        apply = pending_q & (~en_i | sync_i | last);

        div_act_d    = apply ? div_shadow_q : div_act_q;
        div_shadow_d = load_i ? load_div_i : div_shadow_q;
        // A write is only accepted while nothing is pending, so load and apply never coincide.
        pending_d    = load_i | (pending_q & ~apply);

        if (!en_i || sync_i || last) begin
            cnt_p_d = '0;
        end else begin
            cnt_p_d = cnt_p_q + WIDTH'(1);
        end
        // Phase follows the count it will hold, using the divisor of the new period.
        clk_p_d = en_i & ~sync_i & duty_high(32'(cnt_p_d), 32'(div_act_d));
    end

    // Rising-edge state: counter, phase, divisor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p_q      <= '0;
            clk_p_q      <= 1'b0;
            div_act_q    <= DEF;
            div_shadow_q <= DEF;
            pending_q    <= 1'b0;
        end else begin
            cnt_p_q      <= cnt_p_d;
            clk_p_q      <= clk_p_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            pending_q    <= pending_d;
        end
    end

    // Falling-edge copy of the phase, half a cycle late, used to stretch odd divisors.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= en_i & clk_p_q;
        end
    end

    // Output select: pass-through for 1, AND of both edges for odd, rising phase for even.
    always_comb begin
        if (!en_i) begin
            clkout_o = 1'b0;
        end else if (div_act_q == WIDTH'(DIV_MIN)) begin
            clkout_o = clk;
        end else if (div_act_q[0]) begin
            clkout_o = clk_p_q & clk_n_q;
        end else begin
            clkout_o = clk_p_q;
        end
    end

    assign tick_o    = en_i & ~sync_i & last;
    assign pending_o = pending_q;

endmodule

// File: rtl/divide_prog.sv
// Multi-channel runtime-programmable clock divider: config decode and channel array.
module divide_prog import divide_prog_pkg::*; #(
    parameter int CH      = 4,
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] en_i,
    input  logic          sync_all_i,
    divide_prog_if.slave  cfg,
    output logic [CH-1:0] clkout_o,
    output logic [CH-1:0] tick_o
);
    localparam int CHW = ch_width(CH);

    logic [CH-1:0] pending;
    logic [CH-1:0] load;
    logic          ch_ok;
    logic          div_ok;
    logic          accept;
    logic          cfg_err_q, cfg_err_d;

    assign ch_ok  = (int'(cfg.cfg_ch) < CH);
    assign div_ok = (cfg.cfg_div >= WIDTH'(DIV_MIN));
    // Out-of-range channels report ready so the bad write is taken and flagged.
    assign cfg.cfg_ready = ch_ok ? ~pending[cfg.cfg_ch] : 1'b1;
    assign accept    = cfg.cfg_valid & cfg.cfg_ready;
    assign cfg_err_d = accept & ~(ch_ok & div_ok);

    // Error pulse appears the cycle after the rejected write is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg.cfg_err = cfg_err_q;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            assign load[gi] = accept & ch_ok & div_ok & (cfg.cfg_ch == CHW'(gi));

            divide_prog_chan #(
                .WIDTH   (WIDTH),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .en_i       (en_i[gi]),
                .sync_i     (sync_all_i),
                .load_i     (load[gi]),
                .load_div_i (cfg.cfg_div),
                .clkout_o   (clkout_o[gi]),
                .tick_o     (tick_o[gi]),
                .pending_o  (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_divide_prog.sv
// Self-checking bench for divide_prog: waveforms sampled every half clock and
// compared with the ideal pattern "low for N half-cycles, then high for N".
module tb_divide_prog;
    localparam int CH      = 3;
    localparam int WIDTH   = 16;
    localparam int DEF_DIV = 10;
    localparam int CHW     = 2;

    logic          clk;
    logic          rst_n;
    logic          sync_all;
    logic [CH-1:0] en;
    logic [CH-1:0] clkout;
    logic [CH-1:0] tick;

    int checks   = 0;
    int failures = 0;
    int div_m [CH];

    divide_prog_if #(.CH(CH), .WIDTH(WIDTH)) cfg_if ();

    divide_prog #(.CH(CH), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .sync_all_i (sync_all),
        .cfg        (cfg_if),
        .clkout_o   (clkout),
        .tick_o     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Ideal half-cycle samples of a divide-by-n clock from the start of a period.
    function automatic logic [127:0] exp_pat(input int n, input int len);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < len; i++) begin
            if (n == 1) p[i] = (i % 2 == 0);
            else        p[i] = ((i % (2 * n)) >= n);
        end
        return p;
    endfunction

    task automatic capture(input int ch, input int len,
                           output logic [127:0] pat, output logic [127:0] tpat);
        pat  = '0;
        tpat = '0;
        for (int s = 0; s < len; s += 2) begin
            @(posedge clk); #2;
            sync_all = 1'b0;
            pat[s] = clkout[ch];
            @(negedge clk); #2;
            pat[s+1]   = clkout[ch];
            tpat[s/2]  = tick[ch];
        end
    endtask

    task automatic wait_tick(input int ch);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #2;
            seen = tick[ch];
        end
        chk($sformatf("tick_seen_ch%0d", ch), seen, 1'b1);
    endtask

    task automatic measure(input int ch, input int n);
        logic [127:0] pat, tpat;
        wait_tick(ch);
        capture(ch, 2 * n, pat, tpat);
        chk($sformatf("wave_ch%0d_div%0d", ch, n), pat, exp_pat(n, 2 * n));
        chk($sformatf("tick_ch%0d_div%0d", ch, n), tpat, 128'(1) << (n - 1));
    endtask

    task automatic cfg_write(input int ch, input int dv, input logic exp_err);
        cfg_if.cfg_ch    = CHW'(ch);
        cfg_if.cfg_div   = WIDTH'(dv);
        cfg_if.cfg_valid = 1'b1;
        @(posedge clk); #2;
        cfg_if.cfg_valid = 1'b0;
        chk($sformatf("cfg_err_ch%0d_div%0d", ch, dv), cfg_if.cfg_err, exp_err);
        if (exp_err) begin
            @(posedge clk); #2;
            chk("cfg_err_clear", cfg_if.cfg_err, 1'b0);
        end else begin
            chk($sformatf("ready_low_ch%0d", ch), cfg_if.cfg_ready, 1'b0);
            div_m[ch] = dv;
        end
    endtask

    task automatic wait_ready(input int ch);
        logic seen;
        seen = 1'b0;
        cfg_if.cfg_ch = CHW'(ch);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #2;
            seen = cfg_if.cfg_ready;
        end
        chk($sformatf("ready_return_ch%0d", ch), seen, 1'b1);
    endtask

    initial begin
        logic [127:0] pat, pat2, tpat;
        logic seen;
        int ch, dv;

        rst_n = 1'b0;
        en = '0;
        sync_all = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0;
        for (int i = 0; i < CH; i++) div_m[i] = DEF_DIV;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_clkout", clkout, 3'b000);
        chk("rst_tick", tick, 3'b000);
        chk("rst_cfg_err", cfg_if.cfg_err, 1'b0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1'b1);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        chk("idle_clkout", clkout, 3'b000);

        // Default divisor on channel 0
        en = 3'b001;
        measure(0, DEF_DIV);
        measure(0, DEF_DIV);

        // Mid-period rewrite: old period of 10 completes, then period of 4
        wait_tick(0);
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            pat[2*c] = clkout[0];
            if (c == 2) begin
                cfg_if.cfg_ch = 2'd0;
                cfg_if.cfg_div = 16'd4;
                cfg_if.cfg_valid = 1'b1;
            end
            if (c == 3) begin
                cfg_if.cfg_valid = 1'b0;
                chk("midwrite_ready_low", cfg_if.cfg_ready, 1'b0);
            end
            if (c == 9) chk("midwrite_ready_still_low", cfg_if.cfg_ready, 1'b0);
            @(negedge clk); #2;
            pat[2*c+1] = clkout[0];
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            pat[20+2*c] = clkout[0];
            if (c == 0) chk("midwrite_ready_back", cfg_if.cfg_ready, 1'b1);
            @(negedge clk); #2;
            pat[21+2*c] = clkout[0];
        end
        div_m[0] = 4;
        chk("midwrite_wave", pat, exp_pat(10, 20) | (exp_pat(4, 8) << 20));

        // Odd divisor on channel 1, loaded while disabled
        cfg_write(1, 7, 1'b0);
        wait_ready(1);
        en[1] = 1'b1;
        measure(1, 7);

        // Random divisors on random channels
        en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            ch = $urandom_range(0, CH - 1);
            dv = $urandom_range(2, 25);
            cfg_write(ch, dv, 1'b0);
            wait_ready(ch);
            measure(ch, div_m[ch]);
        end

        // Rejected writes leave divisors untouched; divisor 1 passes the clock
        cfg_write(2, 0, 1'b1);
        chk("ready_after_err", cfg_if.cfg_ready, 1'b1);
        cfg_write(CH, 5, 1'b1);
        measure(2, div_m[2]);
        cfg_write(2, 1, 1'b0);
        wait_ready(2);
        measure(2, 1);

        // sync_all aligns channels at 6 and 9, landing on a ch1 wrap cycle
        cfg_write(1, 6, 1'b0);
        wait_ready(1);
        cfg_write(2, 9, 1'b0);
        wait_ready(2);
        wait_tick(1);
        repeat (6) begin @(posedge clk); #2; end
        sync_all = 1'b1;
        @(negedge clk); #2;
        chk("tick_masked_by_sync", tick[1], 1'b0);
        pat = '0;
        pat2 = '0;
        for (int s = 0; s < 18; s += 2) begin
            @(posedge clk); #2;
            sync_all = 1'b0;
            pat[s] = clkout[1];
            pat2[s] = clkout[2];
            @(negedge clk); #2;
            pat[s+1] = clkout[1];
            pat2[s+1] = clkout[2];
        end
        chk("sync_wave_ch1", pat, exp_pat(6, 18));
        chk("sync_wave_ch2", pat2, exp_pat(9, 18));

        // Dropping enable mid-high forces the output low
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #2;
            seen = clkout[1];
        end
        chk("ch1_high_seen", seen, 1'b1);
        en[1] = 1'b0;
        @(negedge clk); #2;
        chk("disable_clkout", clkout[1], 1'b0);
        capture(1, 12, pat, tpat);
        chk("disabled_wave", pat, 128'(0));
        chk("disabled_tick", tpat, 128'(0));

        // Asynchronous reset during a high phase with a pending write
        cfg_write(0, 20, 1'b0);
        wait_ready(0);
        wait_tick(0);
        cfg_write(0, 12, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #2;
            seen = clkout[0];
        end
        chk("ch0_high_before_rst", seen, 1'b1);
        chk("pending_before_rst", cfg_if.cfg_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_clkout", clkout, 3'b000);
        chk("async_rst_tick", tick, 3'b000);
        chk("async_rst_ready", cfg_if.cfg_ready, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < CH; i++) div_m[i] = DEF_DIV;
        measure(0, div_m[0]);
        measure(2, div_m[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
